// File: rtl/otter_cu_pkg.sv
//------------------------------------------------------------------------------
// Module  : otter_cu_pkg
// Brief   : Shared opcode, state and FUNC3 definitions for the OTTER control unit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package otter_cu_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [2:0] FUNC3_MRET  = 3'b000;
    localparam logic [2:0] FUNC3_CSRRW = 3'b001;

endpackage

`default_nettype wire

// File: rtl/otter_cu_fsm.sv
//------------------------------------------------------------------------------
// Module  : otter_cu_fsm
// Brief   : Multicycle FETCH/EXEC/WB control FSM with interrupt entry and INSTRET.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module otter_cu_fsm
    import otter_cu_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int INTR_EN = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       OPCODE,
    input  logic [2:0]       FUNC3,
    input  logic             INTR,
    input  logic             MIE,
    input  logic             MEM_READY,
    output logic             PC_WRITE,
    output logic             PC_RST,
    output logic             MEM_RDEN1,
    output logic             MEM_RDEN2,
    output logic             MEM_WE2,
    output logic             REG_WRITE,
    output logic             CSR_WE,
    output logic             INT_TAKEN,
    output logic             MRET_EXEC,
    output logic [CNT_W-1:0] INSTRET
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   instret_q;
    logic               w_retire;
    logic               w_intr_req;

    assign w_intr_req = (INTR_EN != 0) && INTR && MIE;
    assign INSTRET    = w_intr_req ? instret_q : instret_q;

    always_comb begin
        state_d   = state_q;
        w_retire  = 1'b0;
        PC_WRITE  = 1'b0;
        PC_RST    = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        REG_WRITE = 1'b0;
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;
        case (state_q)
            ST_INIT: begin
                PC_RST  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                MEM_RDEN1 = 1'b1;
                if (MEM_READY) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (OPCODE)
                    OPC_LOAD: begin
                        MEM_RDEN2 = 1'b1;
                    end
                    OPC_STORE: begin
                        MEM_WE2  = 1'b1;
                        PC_WRITE = 1'b1;
                    end
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                        PC_WRITE  = 1'b1;
                        REG_WRITE = 1'b1;
                    end
                    OPC_SYSTEM: begin
                        PC_WRITE = 1'b1;
                        if (FUNC3 == FUNC3_MRET) begin
                            MRET_EXEC = 1'b1;
                        end else if (FUNC3 == FUNC3_CSRRW) begin
                            CSR_WE    = 1'b1;
                            REG_WRITE = 1'b1;
                        end
                    end
                    // Branches and unrecognised opcodes just advance the PC.
                    default: begin
                        PC_WRITE = 1'b1;
                    end
                endcase
                // A load always finishes its WB before an interrupt can be taken.
                if (OPCODE == OPC_LOAD) begin
                    state_d = ST_WB;
                end else begin
                    w_retire = 1'b1;
                    state_d  = w_intr_req ? ST_INTR : ST_FETCH;
                end
            end
            ST_WB: begin
                REG_WRITE = 1'b1;
                PC_WRITE  = 1'b1;
                w_retire  = 1'b1;
                state_d   = w_intr_req ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                INT_TAKEN = 1'b1;
                PC_WRITE  = 1'b1;
                state_d   = ST_FETCH;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_INIT;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
Multicycle control FSM for the OTTER core. Sequences the PC register, instruction/data memory, register file and CSR file through FETCH/EXEC/WB, and arbitrates interrupt entry between instructions. Drives the PC register's PC_WRITE and PC_RST. Also keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of INSTRET counter
INTR_EN, 1, 0 = interrupt path removed (INTR ignored)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
OPCODE  in  7  ir[6:0] of the current instruction
FUNC3  in  3  ir[14:12]
INTR  in  1  external interrupt, already synchronised, level
MIE  in  1  CSR mstatus.MIE
MEM_READY  in  1  instruction fetch data valid; tie 1 for single-cycle memory
PC_WRITE  out  1  PC load enable
PC_RST  out  1  synchronous reset strobe to PC
MEM_RDEN1  out  1  instruction read enable
MEM_RDEN2  out  1  data read enable
MEM_WE2  out  1  data write enable
REG_WRITE  out  1  register-file write enable
CSR_WE  out  1  CSR write enable
INT_TAKEN  out  1  interrupt entry strobe (mepc/mcause capture, PC<-mtvec)
MRET_EXEC  out  1  mret strobe (PC<-mepc, restore MIE)
INSTRET  out  CNT_W  retired-instruction count

Behaviour:
- States: ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR. Moore state register; outputs combinational from state plus OPCODE/FUNC3 in EXEC.
- RST high (async, any time, mid-instruction included): state <= ST_INIT, INSTRET <= 0. Any in-flight instruction is abandoned.
- ST_INIT: PC_RST=1, all other strobes 0. Lasts exactly one cycle after RST deasserts, then ST_FETCH.
- ST_FETCH: MEM_RDEN1=1, all other strobes 0. Stays while MEM_READY=0; goes to ST_EXEC when MEM_READY=1.
- ST_EXEC, decoded on OPCODE:
  - LOAD 0000011: MEM_RDEN2=1, no PC_WRITE; next ST_WB.
  - STORE 0100011: MEM_WE2=1, PC_WRITE=1.
  - BRANCH 1100011: PC_WRITE=1.
  - OP 0110011, OP_IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111: PC_WRITE=1, REG_WRITE=1.
  - SYSTEM 1110011 with FUNC3=000: MRET_EXEC=1, PC_WRITE=1.
  - SYSTEM 1110011 with FUNC3=001 (csrrw): CSR_WE=1, REG_WRITE=1, PC_WRITE=1.
  - Other SYSTEM FUNC3 values and all unknown opcodes: PC_WRITE=1 only; executes as a NOP.
  - Every case except LOAD then makes the interrupt decision.
- ST_WB: REG_WRITE=1, PC_WRITE=1; then makes the interrupt decision.
- Interrupt decision: if INTR_EN && INTR && MIE, next state is ST_INTR; otherwise ST_FETCH. INTR is sampled only on these exit edges. An interrupt never splits a load between EXEC and WB.
- MRET with INTR && MIE both high in the same EXEC cycle: go to ST_INTR. CSR logic updates MIE on the same edge.
- ST_INTR: INT_TAKEN=1, PC_WRITE=1; next ST_FETCH unconditionally. No nesting, because CSR logic clears MIE on INT_TAKEN.
- INSTRET increments by 1 on each clock edge leaving ST_EXEC (non-load) or ST_WB. It does not increment in ST_INTR or ST_INIT. Wraps modulo 2^CNT_W with no saturation.
- Latency: ALU/branch/store instructions take 2 cycles with MEM_READY=1, loads take 3, interrupt entry adds 1.
- At most one of MEM_RDEN2 / MEM_WE2 is high in any cycle. PC_WRITE and PC_RST are never high together.

Decomposition:
- Package otter_cu_pkg holds:
  - opcode_t enum (7-bit values above)
  - state_t enum
  - FUNC3_MRET and FUNC3_CSRRW constants
- No sub-module. The counter and FSM are small enough to stay in one module.

Test Plan:
- Reset then MEM_READY=1, OPCODE=0110011: 1 cycle PC_RST=1, then FETCH, then EXEC with PC_WRITE=REG_WRITE=1; INSTRET=1 after 3 edges.
- OPCODE=0000011 load: EXEC with MEM_RDEN2=1 and PC_WRITE=0, then WB with REG_WRITE=PC_WRITE=1; INSTRET +1 only after WB.
- MEM_READY held 0 for 4 cycles in FETCH: MEM_RDEN1 stays 1, no other strobe, state unchanged; EXEC follows the first MEM_READY=1.
- INTR=1, MIE=1 during a store EXEC: MEM_WE2=1 that cycle, next cycle INT_TAKEN=PC_WRITE=1, then FETCH. Repeat with MIE=0: no INT_TAKEN.
- INTR=1 asserted during a load EXEC: WB completes first, then ST_INTR. Then preload INSTRET to 2^32-1 via a long run and retire one instruction; INSTRET wraps to 0.
- RST pulsed asynchronously (between edges) during ST_WB: outputs go immediately to INIT values (PC_RST=1, REG_WRITE=0), INSTRET=0; normal fetch resumes one cycle after release.
